// File: rtl/pipe_mux_pkg.sv
// Shared constants, width helpers and the default entry layout for the pipelined select mux.
package pipe_mux_pkg;

  localparam int DEF_WIDTH  = 64;
  localparam int DEF_NUM_IN = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // A select bus is never narrower than one bit, even for degenerate counts.
  function automatic int sel_width(input int num_in);
    return (clog2(num_in) < 1) ? 1 : clog2(num_in);
  endfunction

  localparam int DEF_SEL_W = sel_width(DEF_NUM_IN);

  typedef struct packed {
    logic                 err;
    logic [DEF_SEL_W-1:0] sel;
    logic [DEF_WIDTH-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer over an arbitrary packed entry type.
// in_ready is a flop output, so the upstream path never sees out_ready combinationally.
module pipe_skid_buf
  import pipe_mux_pkg::*;
#(
  parameter type entry_t = pipe_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  entry_t in_entry,
  input  logic   in_valid,
  output logic   in_ready,
  output entry_t out_entry,
  output logic   out_valid,
  input  logic   out_ready
);

  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_valid_reg, main_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  logic   accept;
  logic   main_free;

  assign accept    = in_valid & ~skid_valid_reg & ~flush;
  assign main_free = ~main_valid_reg | out_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg) begin
      if (out_ready) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end
    end else if (main_free) begin
      main_valid_next = accept;
      if (accept) begin
        main_next = in_entry;
      end
    end else if (accept) begin
      skid_next       = in_entry;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign in_ready  = ~skid_valid_reg;
  assign out_entry = main_reg;
  assign out_valid = main_valid_reg;

endmodule

// File: rtl/pipe_sel_mux.sv
// N-way operand select with a registered, skid-buffered valid/ready output stage.
// Optional out_sel_err port and error tracking: define PIPE_SEL_MUX_RANGE_CHECK_EN.
module pipe_sel_mux
  import pipe_mux_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NUM_IN = DEF_NUM_IN,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
`ifdef PIPE_SEL_MUX_RANGE_CHECK_EN
  output logic                    out_sel_err,
`endif
  output logic                    out_valid,
  input  logic                    out_ready
);

`ifdef PIPE_SEL_MUX_RANGE_CHECK_EN
  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } entry_t;
`endif

  logic [NUM_IN-1:0] hit;
  logic [WIDTH-1:0]  acc [NUM_IN+1];
  entry_t            sel_entry;
  entry_t            held_entry;

  // One-hot AND-OR select: a select with no matching input yields zero.
  assign acc[0] = '0;
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_sel
      assign hit[gi]    = (in_sel == SEL_W'(gi));
      assign acc[gi+1]  = acc[gi] | (in_data[gi*WIDTH +: WIDTH] & {WIDTH{hit[gi]}});
    end
  endgenerate

  always_comb begin
    sel_entry      = '0;
    sel_entry.data = acc[NUM_IN];
    sel_entry.sel  = in_sel;
`ifdef PIPE_SEL_MUX_RANGE_CHECK_EN
    sel_entry.err  = ~|hit;
`endif
  end

  pipe_skid_buf #(
    .entry_t (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_entry  (sel_entry),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_entry (held_entry),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_data = held_entry.data;
  assign out_sel  = held_entry.sel;
`ifdef PIPE_SEL_MUX_RANGE_CHECK_EN
  assign out_sel_err = held_entry.err;
`endif

endmodule
